// File: rtl/vend_coin_sched.sv
// Coin scheduler: merges two coin slots into a round-robin FIFO, feeds the cola FSM one coin at a time,
// and runs the dispenser req/ack handshake. Optional dispense timeout: define VCS_DISP_TIMEOUT_EN.
module vend_coin_sched #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DISP_TIMEOUT = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       slot_a_one,
    input  logic       slot_a_half,
    input  logic       slot_b_one,
    input  logic       slot_b_half,
    output logic       coin_one_o,
    output logic       coin_half_o,
    input  logic       vend_cola_i,
    input  logic       vend_money_i,
    output logic       disp_req,
    output logic       disp_change,
    input  logic       disp_ack,
    output logic       fifo_full,
    output logic [7:0] drop_cnt,
    output logic       busy,
    output logic       disp_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT     = 2'd2,
        S_DISPENSE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            mem_q [FIFO_DEPTH];
    logic            mem_d [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rr_q, rr_d;
    logic [7:0]      drop_q, drop_d;
    logic            coin_one_q, coin_one_d;
    logic            coin_half_q, coin_half_d;
    logic            req_q, req_d;
    logic            chg_q, chg_d;
    logic            full_q, full_d;
    logic            busy_q, busy_d;

    // Ingress decode; a stored entry is 1 for a one-unit coin, 0 for a half-unit coin.
    logic          a_valid, b_valid, a_ill, b_ill;
    logic          pop;
    logic [CW-1:0] free;
    logic [1:0]    n_coins;
    logic          first_val, second_val;
    logic          wr_first, wr_second;
    logic [2:0]    drops;
    logic [8:0]    drop_sum;

    always_comb begin
        a_valid    = slot_a_one ^ slot_a_half;
        b_valid    = slot_b_one ^ slot_b_half;
        a_ill      = slot_a_one & slot_a_half;
        b_ill      = slot_b_one & slot_b_half;
        pop        = (state_q == S_IDLE) && (count_q != '0);
        free       = CW'(FIFO_DEPTH) - count_q + CW'(pop);
        n_coins    = 2'd0;
        first_val  = 1'b0;
        second_val = 1'b0;
        rr_d       = rr_q;
        if (a_valid && b_valid) begin
            n_coins    = 2'd2;
            first_val  = rr_q ? slot_b_one : slot_a_one;
            second_val = rr_q ? slot_a_one : slot_b_one;
            rr_d       = ~rr_q;
        end else if (a_valid) begin
            n_coins   = 2'd1;
            first_val = slot_a_one;
        end else if (b_valid) begin
            n_coins   = 2'd1;
            first_val = slot_b_one;
        end
        wr_first  = (n_coins != 2'd0) && (free >= CW'(1));
        wr_second = (n_coins == 2'd2) && (free >= CW'(2));
        drops     = 3'(a_ill) + 3'(b_ill)
                  + 3'((n_coins != 2'd0) && !wr_first)
                  + 3'((n_coins == 2'd2) && !wr_second);
        drop_sum  = {1'b0, drop_q} + {6'b0, drops};
        drop_d    = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];

        mem_d = mem_q;
        if (wr_first) begin
            mem_d[wr_ptr_q] = first_val;
        end
        if (wr_second) begin
            mem_d[PW'(wr_ptr_q + 1'b1)] = second_val;
        end
        wr_ptr_d = PW'(wr_ptr_q + PW'(wr_first) + PW'(wr_second));
        rd_ptr_d = PW'(rd_ptr_q + PW'(pop));
        count_d  = count_q + CW'(wr_first) + CW'(wr_second) - CW'(pop);
    end

`ifdef VCS_DISP_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(DISP_TIMEOUT - 1);
    logic [15:0] tmr_q, tmr_d;
    logic        err_q, err_d;
`else
    // Timeout limit has no consumer in this build.
    logic unused_tmo;
    assign unused_tmo = ^32'(DISP_TIMEOUT);
`endif

    // Scheduler: IDLE pops, ISSUE drives the coin pulse, WAIT samples the vending FSM.
    always_comb begin
        state_d     = state_q;
        coin_one_d  = 1'b0;
        coin_half_d = 1'b0;
        req_d       = req_q;
        chg_d       = chg_q;
`ifdef VCS_DISP_TIMEOUT_EN
        tmr_d       = '0;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    coin_one_d  = mem_q[rd_ptr_q];
                    coin_half_d = ~mem_q[rd_ptr_q];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (vend_cola_i) begin
                    req_d   = 1'b1;
                    chg_d   = vend_money_i;
                    state_d = S_DISPENSE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DISPENSE: begin
                if (disp_ack) begin
                    req_d   = 1'b0;
                    chg_d   = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef VCS_DISP_TIMEOUT_EN
                else if (tmr_q == TMO_LAST) begin
                    req_d   = 1'b0;
                    chg_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) || (count_d != '0);
        full_d = (count_d == CW'(FIFO_DEPTH));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 1'b0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rr_q        <= 1'b0;
            drop_q      <= '0;
            coin_one_q  <= 1'b0;
            coin_half_q <= 1'b0;
            req_q       <= 1'b0;
            chg_q       <= 1'b0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
            drop_q      <= drop_d;
            coin_one_q  <= coin_one_d;
            coin_half_q <= coin_half_d;
            req_q       <= req_d;
            chg_q       <= chg_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
        end
    end

`ifdef VCS_DISP_TIMEOUT_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end
    assign disp_err = err_q;
`else
    assign disp_err = 1'b0;
`endif

    assign coin_one_o  = coin_one_q;
    assign coin_half_o = coin_half_q;
    assign disp_req    = req_q;
    assign disp_change = chg_q;
    assign fifo_full   = full_q;
    assign drop_cnt    = drop_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_coin_sched.sv
// Directed bench for vend_coin_sched with a behavioural 2.5-unit cola FSM and a coin scoreboard.
module tb_vend_coin_sched;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       slot_a_one = 1'b0, slot_a_half = 1'b0, slot_b_one = 1'b0, slot_b_half = 1'b0;
    logic       coin_one_o, coin_half_o;
    logic       vend_cola_i, vend_money_i;
    logic       disp_req, disp_change, disp_ack;
    logic       fifo_full, busy, disp_err;
    logic [7:0] drop_cnt;

    logic       man_ack = 1'b0, auto_ack_en = 1'b0, auto_ack_p = 1'b0;
    logic       vm_cola = 1'b0, vm_money = 1'b0;
    int         vm_total = 0;
    int         total = 0, bad = 0;
    int         cyc = 0, last_coin = -100, coin_seen = 0;
    logic [0:0] exp_q[$];

    assign disp_ack     = man_ack | auto_ack_p;
    assign vend_cola_i  = vm_cola;
    assign vend_money_i = vm_money;

    vend_coin_sched #(.FIFO_DEPTH(DEPTH), .DISP_TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .slot_a_one(slot_a_one), .slot_a_half(slot_a_half),
        .slot_b_one(slot_b_one), .slot_b_half(slot_b_half),
        .coin_one_o(coin_one_o), .coin_half_o(coin_half_o),
        .vend_cola_i(vend_cola_i), .vend_money_i(vend_money_i),
        .disp_req(disp_req), .disp_change(disp_change), .disp_ack(disp_ack),
        .fifo_full(fifo_full), .drop_cnt(drop_cnt), .busy(busy), .disp_err(disp_err)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Cola FSM model: price 5 half-units, change when 6 half-units collected.
    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vm_total <= 0;
            vm_cola  <= 1'b0;
            vm_money <= 1'b0;
        end else begin
            vm_cola  <= 1'b0;
            vm_money <= 1'b0;
            if (coin_one_o || coin_half_o) begin
                if (vm_total + (coin_one_o ? 2 : 1) >= 5) begin
                    vm_cola  <= 1'b1;
                    vm_money <= (vm_total + (coin_one_o ? 2 : 1) == 6);
                    vm_total <= 0;
                end else begin
                    vm_total <= vm_total + (coin_one_o ? 2 : 1);
                end
            end
        end
    end

    always @(posedge sys_clk) auto_ack_p <= auto_ack_en && disp_req && !auto_ack_p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // scoreboard: every coin pulse pops the expected queue
    always @(negedge sys_clk) begin
        if (!sys_rst && (coin_one_o || coin_half_o)) begin
            chk("coin_exclusive", 32'(coin_one_o & coin_half_o), 0);
            chk("coin_while_req", 32'(disp_req), 0);
            chk("coin_spacing", 32'((cyc - last_coin) >= 3), 1);
            chk("coin_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("coin_value", 32'(coin_one_o), 32'(exp_q.pop_front()));
            last_coin <= cyc;
            coin_seen <= coin_seen + 1;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic a1, input logic ah, input logic b1, input logic bh);
        slot_a_one = a1; slot_a_half = ah; slot_b_one = b1; slot_b_half = bh;
        tick();
        slot_a_one = 1'b0; slot_a_half = 1'b0; slot_b_one = 1'b0; slot_b_half = 1'b0;
    endtask

    task automatic wait_req(input int lim, input string tag);
        int n = 0;
        while (!disp_req && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(disp_req), 1);
    endtask

    task automatic drain(input int lim, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 0);
        chk({tag, "_queue"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int saved;
        int n;
        tick();
        chk("rst_coin_one", 32'(coin_one_o), 0);
        chk("rst_coin_half", 32'(coin_half_o), 0);
        chk("rst_disp_req", 32'(disp_req), 0);
        chk("rst_disp_change", 32'(disp_change), 0);
        chk("rst_fifo_full", 32'(fifo_full), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_disp_err", 32'(disp_err), 0);
        sys_rst = 1'b0;
        tick();

        // three one-unit coins on A -> cola with change
        repeat (3) begin exp_q.push_back(1'b1); drive(1, 0, 0, 0); end
        wait_req(40, "s1_req");
        chk("s1_change", 32'(disp_change), 1);
        chk("s1_busy", 32'(busy), 1);
        chk("s1_coins", 32'(coin_seen), 3);
        repeat (5) tick();
        chk("s1_req_held", 32'(disp_req), 1);
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        chk("s1_req_clear", 32'(disp_req), 0);
        chk("s1_change_clear", 32'(disp_change), 0);
        chk("s1_busy_end", 32'(busy), 0);

        // both slots half, two cycles
        repeat (4) exp_q.push_back(1'b0);
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 1);
        drain(40, "s2_drain");
        chk("s2_drop", 32'(drop_cnt), 0);
        chk("s2_coins", 32'(coin_seen), 7);

        // burst of 6 while dispensing: 4 stored, 2 dropped
        exp_q.push_back(1'b1);
        drive(1, 0, 0, 0);
        wait_req(20, "s3_req");
        chk("s3_change", 32'(disp_change), 1);
        repeat (6) drive(0, 1, 0, 0);
        repeat (4) exp_q.push_back(1'b0);
        chk("s3_full", 32'(fifo_full), 1);
        chk("s3_drop", 32'(drop_cnt), 2);
        chk("s3_no_issue", 32'(coin_seen), 8);
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        chk("s3_req_clear", 32'(disp_req), 0);
        drain(60, "s3_drain");
        chk("s3_full_end", 32'(fifo_full), 0);
        chk("s3_coins", 32'(coin_seen), 12);

        // illegal one+half on B
        drive(0, 0, 1, 1);
        chk("s4_drop", 32'(drop_cnt), 3);
        chk("s4_busy", 32'(busy), 0);
        repeat (5) tick();
        chk("s4_coins", 32'(coin_seen), 12);

        // mixed values, pointer at A: order A1 B0, then B0 A1
        auto_ack_en = 1'b1;
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        drive(1, 0, 0, 1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        drive(1, 0, 0, 1);
        drain(80, "s5_drain");
        chk("s5_drop", 32'(drop_cnt), 3);
        chk("s5_coins", 32'(coin_seen), 16);
        auto_ack_en = 1'b0;
        repeat (2) tick();

        // reset during DISPENSE with three coins queued
        exp_q.push_back(1'b1);
        drive(1, 0, 0, 0);
        wait_req(20, "s6_req");
        repeat (3) drive(1, 0, 0, 0);
        #3 sys_rst = 1'b1;
        #1;
        chk("s6_req_async", 32'(disp_req), 0);
        chk("s6_busy", 32'(busy), 0);
        chk("s6_full", 32'(fifo_full), 0);
        chk("s6_drop", 32'(drop_cnt), 0);
        exp_q.delete();
        saved = coin_seen;
        tick(); tick();
        sys_rst = 1'b0;
        repeat (15) tick();
        chk("s6_no_coins", 32'(coin_seen), 32'(saved));
        chk("s6_busy_after", 32'(busy), 0);

`ifdef VCS_DISP_TIMEOUT_EN
        // withheld ack: timeout after TMO cycles, then the queued coin issues
        repeat (3) begin exp_q.push_back(1'b1); drive(1, 0, 0, 0); end
        wait_req(40, "s7_req");
        exp_q.push_back(1'b0);
        drive(0, 1, 0, 0);
        n = 1;
        while (disp_req && n < 30) begin
            tick();
            n++;
        end
        chk("s7_req_len", 32'(n), TMO);
        chk("s7_err", 32'(disp_err), 1);
        drain(30, "s7_drain");
        chk("s7_err_sticky", 32'(disp_err), 1);
        chk("s7_coins", 32'(coin_seen), 32'(saved + 4));
`else
        n = 0;
        chk("s7_err_tied", 32'(disp_err), 32'(n));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
